// File: rtl/tone_sequencer_if.sv
// Control, note-ROM and tone_generator signals of tone_sequencer, bundled as one port.
// master = control logic + note ROM side; slave = the sequencer.
interface tone_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              play;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] note_addr;
    logic [39:0]       note_data;
    logic [23:0]       tone_switch_period;
    logic              output_enable;
    logic              busy;
    logic              paused;
    logic              done;

    modport master (
        output play, pause, stop, loop_en, start_addr, note_data,
        input  note_addr, tone_switch_period, output_enable, busy, paused, done
    );

    modport slave (
        input  play, pause, stop, loop_en, start_addr, note_data,
        output note_addr, tone_switch_period, output_enable, busy, paused, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Melody sequencer: walks {period, duration} entries of a synchronous note ROM,
// times each note in tempo ticks and drives tone_generator's period/enable.
module tone_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_TICKS   = 10
) (
    input  logic             clk,
    input  logic             rst,
    tone_sequencer_if.slave  bus
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [15:0]       GAP_LOAD  = 16'(GAP_TICKS);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSED} state_t;

    state_t            state;
    state_t            saved_state;
    logic [ADDR_W-1:0] note_addr;
    logic [23:0]       period;
    logic              oe;
    logic              done;
    logic [TICK_W-1:0] tick_cnt;
    logic [15:0]       dur_cnt;

    logic [23:0] rom_period;
    logic [15:0] rom_dur;
    logic        tick;

    assign rom_period = bus.note_data[39:16];
    assign rom_dur    = bus.note_data[15:0];
    assign tick       = (tick_cnt == TICK_LAST);

    // dur_cnt counts note ticks in PLAY and is reloaded with the gap length in GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            saved_state <= IDLE;
            note_addr   <= '0;
            period      <= '0;
            oe          <= 1'b0;
            done        <= 1'b0;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (bus.stop && state != IDLE) begin
                state  <= IDLE;
                oe     <= 1'b0;
                period <= '0;
            end else if (bus.pause && (state == PLAY || state == GAP)) begin
                // counters stay put, so a tick landing on this edge is replayed on resume
                saved_state <= state;
                state       <= PAUSED;
                oe          <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.play) begin
                            note_addr <= bus.start_addr;
                            state     <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        if (rom_dur == 16'd0) begin
                            if (bus.loop_en) begin
                                note_addr <= bus.start_addr;
                                state     <= FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            period   <= rom_period;
                            oe       <= |rom_period;
                            dur_cnt  <= rom_dur;
                            tick_cnt <= '0;
                            state    <= PLAY;
                        end
                    end
                    PLAY, GAP: begin
                        if (tick) begin
                            tick_cnt <= '0;
                            if (dur_cnt == 16'd1) begin
                                oe <= 1'b0;
                                if (state == PLAY && GAP_TICKS > 0) begin
                                    dur_cnt <= GAP_LOAD;
                                    state   <= GAP;
                                end else begin
                                    dur_cnt   <= '0;
                                    note_addr <= note_addr + ADDR_W'(1);
                                    state     <= FETCH;
                                end
                            end else begin
                                dur_cnt <= dur_cnt - 16'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    PAUSED: begin
                        if (bus.play) begin
                            state <= saved_state;
                            if (saved_state == PLAY) oe <= |period;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.note_addr          = note_addr;
    assign bus.tone_switch_period = period;
    assign bus.output_enable      = oe;
    assign bus.done               = done;
    assign bus.busy               = (state != IDLE);
    assign bus.paused             = (state == PAUSED);
endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized scoreboard bench for tone_sequencer: a note-level timeline model
// produces the expected per-cycle outputs, a negedge monitor pops and compares.
module tb_tone_sequencer;
    localparam int AW   = 4;
    localparam int TC   = 4;
    localparam int GT   = 1;
    localparam int MAXN = 512;

    typedef struct {
        logic [23:0]   period;
        logic          oe;
        logic          busy;
        logic          paused;
        logic          done;
        logic [AW-1:0] addr;
        bit            pz;      // sequencer sits in PLAY/GAP after this edge
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tone_sequencer_if #(.ADDR_W(AW)) bus();
    tone_sequencer #(.ADDR_W(AW), .TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [39:0] rom [0:15];
    always @(posedge clk) bus.note_data <= rom[bus.note_addr];

    exp_t tl [MAXN];
    int   tl_len;
    exp_t sbq [$];
    exp_t last;
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   samp   = 0;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (bus.tone_switch_period !== mon_e.period || bus.output_enable !== mon_e.oe ||
                bus.busy !== mon_e.busy || bus.paused !== mon_e.paused ||
                bus.done !== mon_e.done || bus.note_addr !== mon_e.addr) begin
                errors++;
                $display("FAIL sample %0d: got period=%0d oe=%b busy=%b paused=%b done=%b addr=%0d, expected period=%0d oe=%b busy=%b paused=%b done=%b addr=%0d",
                         samp, bus.tone_switch_period, bus.output_enable, bus.busy, bus.paused,
                         bus.done, bus.note_addr, mon_e.period, mon_e.oe, mon_e.busy,
                         mon_e.paused, mon_e.done, mon_e.addr);
            end
            samp++;
        end
    end

    function automatic void add(logic [23:0] p, logic oe, logic busy, logic done,
                                logic [AW-1:0] a, bit pz);
        if (tl_len < MAXN) begin
            tl[tl_len] = '{p, oe, busy, 1'b0, done, a, pz};
            tl_len++;
        end
    endfunction

    // Melody timeline for a play issued at edge 0: entry i = outputs after edge i.
    // Each note: 2 fetch cycles, dur*TC sounding cycles, GT*TC silent gap cycles.
    task automatic build(input logic [AW-1:0] sa, input bit lp, input logic [23:0] p0,
                         output int done_idx);
        logic [AW-1:0] a;
        logic [23:0]   cur;
        logic [23:0]   p;
        int            d;
        a = sa; cur = p0; tl_len = 0; done_idx = -1;
        while (tl_len < MAXN) begin
            add(cur, 1'b0, 1'b1, 1'b0, a, 1'b0);
            add(cur, 1'b0, 1'b1, 1'b0, a, 1'b0);
            p = rom[a][39:16];
            d = int'(rom[a][15:0]);
            if (d == 0) begin
                if (lp) a = sa;
                else begin
                    done_idx = tl_len;
                    add(cur, 1'b0, 1'b0, 1'b1, a, 1'b0);
                    while (tl_len < MAXN) add(cur, 1'b0, 1'b0, 1'b0, a, 1'b0);
                end
            end else begin
                cur = p;
                for (int i = 0; i < d * TC; i++) add(cur, p != 24'd0, 1'b1, 1'b0, a, 1'b1);
                for (int i = 0; i < GT * TC; i++) add(cur, 1'b0, 1'b1, 1'b0, a, 1'b1);
                a = a + AW'(1);
            end
        end
    endtask

    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        rst = 1'b0; bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        sbq.push_back(e);
        last = e;
    endtask

    // abort_kind: 0 stop, 1 rst, 2 stop+pause+play together
    task automatic scenario(input logic [AW-1:0] sa, input bit lp, input int pause_at,
                            input int pause_len, input int abort_at, input int abort_kind,
                            input bit idle_pause, input bit noise);
        int   done_idx, k, c, end_k;
        exp_t e;
        build(sa, lp, last.period, done_idx);
        end_k = (done_idx >= 0) ? done_idx + 3 : MAXN - 1;
        bus.start_addr = sa; bus.loop_en = lp; bus.play = 1'b1; bus.pause = idle_pause;
        step(tl[0]);
        k = 1; c = 1;
        while (k < end_k) begin
            if (c == abort_at && last.busy) begin
                if (abort_kind == 1) begin
                    rst = 1'b1;
                    e = '{24'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0};
                end else begin
                    bus.stop = 1'b1;
                    if (abort_kind == 2) begin bus.pause = 1'b1; bus.play = 1'b1; end
                    e = '{24'd0, 1'b0, 1'b0, 1'b0, 1'b0, last.addr, 1'b0};
                end
                step(e); step(e); step(e);
                break;
            end else if (c == pause_at && tl[k-1].pz) begin
                e = tl[k-1]; e.oe = 1'b0; e.paused = 1'b1; e.pz = 1'b0;
                bus.pause = 1'b1;
                step(e);
                for (int i = 1; i < pause_len; i++) begin
                    bus.pause = ($urandom_range(0, 3) == 0);
                    step(e);
                end
                bus.play = 1'b1;
                step(tl[k-1]);
                c += pause_len + 1;
            end else begin
                if (c == pause_at) bus.pause = 1'b1;
                if (noise && tl[k-1].busy && $urandom_range(0, 7) == 0) bus.play = 1'b1;
                if (noise && tl[k-1].busy && !tl[k-1].pz && $urandom_range(0, 3) == 0)
                    bus.pause = 1'b1;
                step(tl[k]);
                k++; c++;
            end
        end
    endtask

    initial begin
        logic [AW-1:0] sa, mi;
        logic [23:0]   per;
        bit            lp;
        int            pa, pl, ab, ak;
        exp_t          rst_e;
        rst = 1'b1; bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        bus.loop_en = 1'b0; bus.start_addr = '0;
        for (int i = 0; i < 16; i++) rom[i] = 40'd0;
        rst_e = '{24'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0};
        last  = rst_e;
        repeat (3) begin rst = 1'b1; step(rst_e); end

        // basic two-note melody ending in a marker
        rom[0] = {24'd100, 16'd2}; rom[1] = {24'd200, 16'd1}; rom[2] = {24'd999, 16'd0};
        scenario(4'd0, 1'b0, -1, 0, -1, 0, 1'b0, 1'b0);
        // rest note
        rom[5] = {24'd0, 16'd3}; rom[6] = {24'd77, 16'd1}; rom[7] = {24'd5, 16'd0};
        scenario(4'd5, 1'b0, -1, 0, -1, 0, 1'b0, 1'b0);
        // pause 3 cycles into the first note, held 20 cycles
        scenario(4'd0, 1'b0, 5, 20, -1, 0, 1'b0, 1'b0);
        // pause on the tick that ends the note
        scenario(4'd0, 1'b0, 10, 3, -1, 0, 1'b0, 1'b0);
        // looping single note
        rom[3] = {24'd50, 16'd1}; rom[4] = {24'd1, 16'd0};
        scenario(4'd3, 1'b1, -1, 0, 40, 0, 1'b0, 1'b0);
        // stop, rst, then stop+pause+play mid-note; each followed by a clean restart
        scenario(4'd0, 1'b0, -1, 0, 4, 0, 1'b0, 1'b0);
        scenario(4'd0, 1'b0, -1, 0, 12, 1, 1'b0, 1'b0);
        scenario(4'd0, 1'b0, -1, 0, 6, 2, 1'b0, 1'b0);
        scenario(4'd0, 1'b0, -1, 0, -1, 0, 1'b1, 1'b0);
        // address wrap 15 -> 0
        rom[14] = {24'd11, 16'd1}; rom[15] = {24'd22, 16'd1};
        rom[0]  = {24'd33, 16'd1}; rom[1]  = {24'd0, 16'd0};
        scenario(4'd14, 1'b0, -1, 0, -1, 0, 1'b0, 1'b1);

        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < 16; i++) begin
                per = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
                rom[i] = {per, 16'($urandom_range(1, 3))};
            end
            sa = AW'($urandom_range(0, 15));
            mi = sa + AW'($urandom_range(1, 5));
            rom[mi] = {24'($urandom), 16'd0};
            lp = ($urandom_range(0, 5) == 0);
            pa = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(2, 60));
            pl = int'($urandom_range(1, 12));
            ab = lp ? int'($urandom_range(30, 80))
                    : (($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 40)) : -1);
            ak = int'($urandom_range(0, 2));
            scenario(sa, lp, pa, pl, ab, ak, $urandom_range(0, 3) == 0, 1'b1);
        end

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d samples left in queue, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
